// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU: steps an 8-phase
// instruction cycle, decodes memory/register strobes and freezes on HLT.
module cpu_sequencer #(
  parameter int OPCODE_W  = 3,
  parameter bit USE_READY = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                a_is_zero,
  input  logic                mem_ready,
  output logic [OPCODE_W-1:0] alu_opcode,
  output logic [2:0]          phase,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                ld_ac,
  output logic                wr,
  output logic                data_e,
  output logic                halt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

  phase_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic                halted_q, halted_d;
  logic                stall;
  logic                is_aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INST_ADDR;
      opcode_q <= OP_HLT;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      halted_q <= halted_d;
    end
  end

  // Only the two fetch phases wait on memory; every other phase advances unconditionally.
  assign stall = USE_READY && ((state_q == INST_FETCH) || (state_q == OP_FETCH)) && !mem_ready;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if ((state_q == OP_ADDR) && (opcode_q == OP_HLT)) begin
        halted_d = 1'b1;
      end else if (!stall) begin
        state_d = phase_t'(3'(state_q + 3'd1));
        if (state_q == INST_LOAD) begin
          opcode_d = ir_opcode;
        end
      end
    end
  end

  assign is_aluop = (opcode_q == OP_ADD) || (opcode_q == OP_AND) ||
                    (opcode_q == OP_XOR) || (opcode_q == OP_LDA);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (state_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (opcode_q != OP_HLT);
          halt   = (opcode_q == OP_HLT);
        end
        OP_FETCH: begin
          rd = is_aluop;
        end
        ALU_OP: begin
          rd     = is_aluop;
          inc_pc = (opcode_q == OP_SKZ) && a_is_zero;
          ld_pc  = (opcode_q == OP_JMP);
          data_e = (opcode_q == OP_STO);
        end
        STORE: begin
          rd     = is_aluop;
          ld_pc  = (opcode_q == OP_JMP);
          data_e = (opcode_q == OP_STO);
          wr     = (opcode_q == OP_STO);
          ld_ac  = is_aluop;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase      = state_q;
  assign alu_opcode = opcode_q;

endmodule
